mem_handshake_ram: RTL
======================

MEM_HANDSHAKE_RAM -- requirements
Module: mem_handshake_ram

Interface
REQ-001 Parameter DEPTH, default 512, memory size in bytes, power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request capture to MOC, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MOV  input  1  memory operation valid from the datapath; held high until MOC is seen.
REQ-006 RW  input  1  1 = read, 0 = write.
REQ-007 Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-008 Address  input  32  byte address (datapath MAR).
REQ-009 DataIn  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
REQ-010 DataOut  output  32  read data to the datapath instruction register/MDR.
REQ-011 MOC  output  1  memory operation complete.
REQ-012 MErr  output  1  misaligned-access flag, valid while MOC is high.

Function
REQ-013 Three-state FSM SHALL be used: IDLE, BUSY, DONE.
REQ-014 IDLE: on MOV=1, capture RW, Size, Address and DataIn; load the latency counter with LATENCY-1; go to BUSY.
REQ-015 BUSY: decrement the counter; at 0, perform the access and go to DONE.
REQ-016 DONE: MOC=1; DataOut and MErr hold stable; return to IDLE when MOV=0, else remain.
REQ-017 MOC SHALL be 1 only in DONE, so latency from the MOV-sampling edge to MOC high is LATENCY+1 edges.
REQ-018 Effective address SHALL be Address modulo DEPTH (wrap-around); upper bits are ignored.
REQ-019 Byte order SHALL be big-endian: the word at A is {M[A],M[A+1],M[A+2],M[A+3]}.
REQ-020 Read byte: DataOut = {24'b0, M[A]}; read half: {16'b0, M[A], M[A+1]}; read word: all four bytes.
REQ-021 Write SHALL update only the selected bytes; DataOut keeps its previous value.
REQ-022 Misalignment (half with A[0]=1; word with A[1:0]!=0): no memory update, DataOut = 0, MErr = 1, MOC still asserted.
REQ-023 Input changes while in BUSY or DONE SHALL be ignored; only the captured request is used.
REQ-024 MOV=1 held after MOC SHALL NOT start a second access until MOV has been low for at least one cycle in DONE.
REQ-025 MErr SHALL clear on the IDLE->BUSY transition of the next request.

Reset
REQ-026 Reset SHALL force IDLE, MOC=0, MErr=0, DataOut=0, counter=0 and captured fields=0.
REQ-027 Reset in BUSY SHALL abort the access with no memory write; reset in DONE SHALL drop MOC on the next edge.
REQ-028 Memory array contents SHALL NOT be affected by reset; initial contents SHALL be loadable by the bench via a preload task or file.

Structure
REQ-029 A shared package SHALL hold the Size encodings, FSM state encodings and the RW read/write constants.
REQ-030 The byte array SHALL be one sub-module, mem_byte_array, with 4 byte-lane write enables, 4 read lanes and DEPTH/address width as parameters.
REQ-031 Address-lane generation, alignment checking and read/write data steering SHALL live in mem_handshake_ram.

Verification
REQ-032 Preload M[0..3]=8'h12,34,56,78; word read at 0 -> MOC after LATENCY+1 edges with DataOut=32'h12345678 and MErr=0.
REQ-033 Halfword write of DataIn=32'hFFFFABCD at 6, then word read at 4 -> bytes 4,5 unchanged and bytes 6,7 = AB,CD.
REQ-034 Byte read at Address=32'h00000203 with DEPTH=512 -> returns M[3], zero-extended (wrap-around).
REQ-035 Word write at 2 -> MErr=1, DataOut=0, memory unchanged, and the next aligned request clears MErr.
REQ-036 Assert reset in BUSY during a word write at 8 -> MOC never rises and a later read at 8 returns the old data.
REQ-037 Hold MOV high for 5 cycles after MOC -> exactly one access occurs and MOC stays high until MOV falls.

Source files
------------

// File: rtl/mem_handshake_ram_pkg.sv
// Shared encodings for the handshake RAM: access sizes, FSM states and RW polarity.
package mem_handshake_ram_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_handshake_ram_if.sv
// Datapath <-> memory handshake bus (MOV/MOC request-complete protocol).
interface mem_handshake_ram_if;

    logic        MOV;
    logic        RW;
    logic [1:0]  Size;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        MErr;

    modport master (
        output MOV, RW, Size, Address, DataIn,
        input  DataOut, MOC, MErr
    );

    modport slave (
        input  MOV, RW, Size, Address, DataIn,
        output DataOut, MOC, MErr
    );

endinterface

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four independent lanes; each lane has its own address,
// write enable and asynchronous read port. Contents are never touched by reset.
module mem_byte_array #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [3:0]          we,
    input  logic [3:0][AW-1:0]  addr,
    input  logic [3:0][7:0]     wdata,
    output logic [3:0][7:0]     rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr[i]] <= wdata[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = mem[addr[i]];
        end
    end

endmodule

// File: rtl/mem_handshake_ram.sv
// Big-endian byte-addressed RAM behind a MOV/MOC handshake with a fixed access
// latency; handles lane steering, alignment checking and address wrap-around.
module mem_handshake_ram
    import mem_handshake_ram_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_handshake_ram_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e              state;
    logic [3:0]          cnt;
    logic                cap_rw;
    size_e               cap_size;
    logic [AW-1:0]       cap_addr;
    logic [31:0]         cap_data;

    logic                misaligned;
    logic                access;
    logic [3:0]          lane_en;
    logic [3:0]          lane_we;
    logic [3:0][AW-1:0]  lane_addr;
    logic [3:0][7:0]     lane_wdata;
    logic [3:0][7:0]     lane_rdata;
    logic [31:0]         rd_word;
    logic                addr_unused;

    // Bits above the array size are deliberately ignored (modulo-DEPTH wrap).
    assign addr_unused = ^bus.Address[31:AW];

    always_comb begin
        misaligned = 1'b0;
        lane_en    = 4'b0000;
        lane_wdata = '0;
        rd_word    = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = cap_addr + AW'(i);
        end
        // Lane 0 is always the byte at the captured address (big-endian MSB).
        case (cap_size)
            SIZE_BYTE: begin
                lane_en       = 4'b0001;
                lane_wdata[0] = cap_data[7:0];
                rd_word       = {24'b0, lane_rdata[0]};
            end
            SIZE_HALF: begin
                misaligned    = cap_addr[0];
                lane_en       = 4'b0011;
                lane_wdata[0] = cap_data[15:8];
                lane_wdata[1] = cap_data[7:0];
                rd_word       = {16'b0, lane_rdata[0], lane_rdata[1]};
            end
            default: begin
                misaligned    = (cap_addr[1:0] != 2'b00);
                lane_en       = 4'b1111;
                lane_wdata[0] = cap_data[31:24];
                lane_wdata[1] = cap_data[23:16];
                lane_wdata[2] = cap_data[15:8];
                lane_wdata[3] = cap_data[7:0];
                rd_word       = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
            end
        endcase
        access  = (state == ST_BUSY) && (cnt == 4'd0);
        lane_we = (access && cap_rw == RW_WRITE && !misaligned && !reset) ? lane_en : 4'b0000;
    end

    mem_byte_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (lane_we),
        .addr  (lane_addr),
        .wdata (lane_wdata),
        .rdata (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            cap_rw      <= 1'b0;
            cap_size    <= SIZE_BYTE;
            cap_addr    <= '0;
            cap_data    <= '0;
            bus.MOC     <= 1'b0;
            bus.MErr    <= 1'b0;
            bus.DataOut <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.MOV) begin
                        cap_rw   <= bus.RW;
                        cap_size <= size_e'(bus.Size);
                        cap_addr <= bus.Address[AW-1:0];
                        cap_data <= bus.DataIn;
                        cnt      <= 4'(LATENCY - 1);
                        bus.MErr <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_DONE;
                        bus.MOC <= 1'b1;
                        if (misaligned) begin
                            bus.DataOut <= '0;
                            bus.MErr    <= 1'b1;
                        end else if (cap_rw == RW_READ) begin
                            bus.DataOut <= rd_word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // A held MOV keeps us parked here; only a low MOV re-arms.
                    if (!bus.MOV) begin
                        bus.MOC <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
